mc_control_fsm: RTL
===================

// Module: mc_control_fsm
// PURPOSE
//  Parametrised multicycle MIPS control FSM with memory wait-states, MULT/DIV completion wait and a watchdog.
//  Precise exceptions: overflow, div-by-zero, invalid opcode, mult/div timeout; each saves EPC and jumps via a memory vector.
//  Sits between IR decode fields and the datapath muxes/enables of the multicycle CPU.
// PARAMETERS
//  DATA_W     32    datapath width; width of pc and exc_vector
//  MD_TIMEOUT 40    max cycles in MD_WAIT before timeout exception (>=2)
//  EN_MDTO    1     1 = enable watchdog; 0 = MD_WAIT waits forever
//  VEC_OPC    255   vector byte address, invalid opcode   | VEC_DZ 254 div-by-zero
//  VEC_OVF    253   vector byte address, overflow         | VEC_MDTO 252 mult/div timeout
// PORTS
//  clk          in  1       system clock, rising edge
//  reset_n      in  1       asynchronous, active-low reset
//  opcode       in  6       IR[31:26]          | funct in 6 IR[5:0]
//  alu_zero     in  1       ALU zero flag      | alu_overflow in 1 signed overflow flag, valid in EXEC
//  divisor_zero in  1       rt register value == 0
//  mult_done    in  1       multiplier result valid | div_done in 1 divider result valid
//  mem_ready    in  1       memory access complete this cycle
//  pc_write     out 1       PC load            | pc_src out 2  00 ALU, 01 ALUOut, 10 jump target, 11 MDR
//  iord         out 2       mem addr: 00 PC, 01 ALUOut, 10 exc_vector
//  mem_read / mem_write / ir_write / reg_write  out 1 each  strobes
//  reg_dst      out 2       00 rt, 01 rd, 11 $ra
//  alu_src_a    out 1       0 PC, 1 A          | alu_src_b out 2  00 B, 01 const 4, 10 sext imm, 11 sext imm<<2
//  alu_op       out 4       ADD/SUB/FUNCT/CMP codes from ctrl_defs.vh
//  wb_src       out 3       000 ALUOut, 001 MDR, 010 HI, 011 LO, 100 PC
//  mult_start / div_start / hi_write / lo_write / epc_write  out 1 each
//  exc_code     out 3       000 none, 001 ovf, 010 dz, 011 mdto, 100 opcode; registered
//  exc_vector   out DATA_W  zero-extended vector byte for the pending exception
// BEHAVIOUR
//  Reset: state=RESET, watchdog=0, exc_code=0, ovf_latch=0; every output 0 while reset_n=0. RESET->FETCH.
//  Outputs are Moore decodes of state/opcode/funct; default 0 in every state.
//  FETCH: iord=00, mem_read=1; stay until mem_ready. On the ready cycle: ir_write, pc_write, pc_src=00, src_b=01, ADD -> DECODE.
//  DECODE: src_a=0, src_b=11, ADD (branch target -> ALUOut). Unknown opcode/funct -> EXC_SAVE, code 100. Else -> EXEC.
//  EXEC R-ALU/ADDI: ovf_latch <= alu_overflow for ADD/SUB/ADDI only -> WB.
//  EXEC LW/SW: src_a=1, src_b=10, ADD -> MEM.
//  EXEC BEQ/BNE: SUB; pc_write=1, pc_src=01 iff alu_zero==(opcode==BEQ) -> FETCH.
//  EXEC J/JAL/JR: pc_write=1, pc_src=10 (JR: 00 with src_a=1, src_b=00 pass); JAL also reg_write, reg_dst=11, wb_src=100 -> FETCH.
//  EXEC MULT: mult_start 1-cycle pulse -> MD_WAIT.
//  EXEC DIV: if divisor_zero, no div_start and -> EXC_SAVE code 010; else div_start pulse -> MD_WAIT.
//  EXEC MFHI/MFLO: reg_write, reg_dst=01, wb_src 010/011 -> FETCH.
//  MD_WAIT: watchdog++ per cycle. On done: hi_write=lo_write=1 -> FETCH.
//   If watchdog==MD_TIMEOUT-1 and EN_MDTO -> EXC_SAVE code 011. Done and timeout same cycle: done wins.
//  MEM: iord=01. LW: mem_read until mem_ready -> WB.
//   SW: mem_write held until mem_ready -> FETCH (exactly one accepted write).
//  WB: ovf_latch=1 -> reg_write suppressed, -> EXC_SAVE code 001. Else reg_write=1 -> FETCH.
//   R: reg_dst=01, wb 000. ADDI: reg_dst=00. LW: reg_dst=00, wb 001.
//  EXC_SAVE: src_a=0, src_b=01, SUB (PC-4); epc_write=1 one cycle -> EXC_LOAD.
//  EXC_LOAD: iord=10, mem_read until mem_ready -> EXC_JUMP.
//  EXC_JUMP: pc_write, pc_src=11 -> FETCH; ovf_latch cleared.
//  exc_code set on entry to EXC_SAVE; holds until next exception or reset.
//  mult_done/div_done outside MD_WAIT ignored; watchdog cleared on MD_WAIT exit.
//  reset_n low in any state (incl. mid-MD_WAIT or mid-memory wait): immediate return to RESET, no further strobes.
// STRUCTURE
//  ctrl_defs.vh: state encodings (4-bit), opcode/funct constants, alu_op codes, exc codes, mux select codes.
//  Sub-module md_watchdog: counter, clear/enable inputs, timeout output, width $clog2(MD_TIMEOUT).
//  Top: state register, next-state logic, output decode, exc_code and ovf_latch registers.
// TESTING
//  ADD with $t=0x7FFFFFFF+1, mem_ready=1 -> no reg_write; epc_write; EXC_LOAD iord=10; exc_vector=253; exc_code=001.
//  DIV with divisor_zero=1 -> div_start never asserted; exc_code=010; exc_vector=254.
//  MULT, mult_done after 5 cycles -> hi_write=lo_write=1 on that cycle; next state FETCH.
//  MULT, no done, MD_TIMEOUT=40 -> EXC_SAVE exactly 40 cycles after entering MD_WAIT; code 011.
//   Also: done on the timeout cycle -> no exception.
//  LW with mem_ready low 3 cycles -> mem_read held 4 cycles, one reg_write; SW -> mem_write held 4 cycles.
//  reset_n low mid-MD_WAIT then high -> all outputs 0; FETCH follows RESET; a late mult_done is ignored.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes, ALU codes,
// exception codes, datapath mux selects and the instruction-class decoder.
package mc_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC     = 4'd3,
    S_MD_WAIT  = 4'd4,
    S_MEM      = 4'd5,
    S_WB       = 4'd6,
    S_EXC_SAVE = 4'd7,
    S_EXC_LOAD = 4'd8,
    S_EXC_JUMP = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    EXC_NONE = 3'b000,
    EXC_OVF  = 3'b001,
    EXC_DZ   = 3'b010,
    EXC_MDTO = 3'b011,
    EXC_OPC  = 3'b100
  } exc_t;

  typedef enum logic [3:0] {
    IC_RALU, IC_ADDI, IC_LW, IC_SW, IC_BRANCH, IC_JUMP, IC_JAL, IC_JR,
    IC_MULT, IC_DIV, IC_MFHI, IC_MFLO, IC_INVALID
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_FUNCT = 4'd2;
  localparam logic [3:0] ALU_CMP   = 4'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_MDR    = 2'b11;

  localparam logic [1:0] IORD_PC     = 2'b00;
  localparam logic [1:0] IORD_ALUOUT = 2'b01;
  localparam logic [1:0] IORD_VEC    = 2'b10;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [2:0] WB_ALUOUT = 3'b000;
  localparam logic [2:0] WB_MDR    = 3'b001;
  localparam logic [2:0] WB_HI     = 3'b010;
  localparam logic [2:0] WB_LO     = 3'b011;
  localparam logic [2:0] WB_PC     = 3'b100;

  function automatic iclass_t decode_class(input logic [5:0] op, input logic [5:0] fn);
    iclass_t ic;
    ic = IC_INVALID;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ic = IC_RALU;
          FN_JR:   ic = IC_JR;
          FN_MULT: ic = IC_MULT;
          FN_DIV:  ic = IC_DIV;
          FN_MFHI: ic = IC_MFHI;
          FN_MFLO: ic = IC_MFLO;
          default: ic = IC_INVALID;
        endcase
      end
      OP_J:           ic = IC_JUMP;
      OP_JAL:         ic = IC_JAL;
      OP_BEQ, OP_BNE: ic = IC_BRANCH;
      OP_ADDI:        ic = IC_ADDI;
      OP_LW:          ic = IC_LW;
      OP_SW:          ic = IC_SW;
      default:        ic = IC_INVALID;
    endcase
    return ic;
  endfunction

  // Only signed-arithmetic instructions may raise overflow; logic ops and SLT never do.
  function automatic logic is_arith(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_ADDI) || ((op == OP_RTYPE) && ((fn == FN_ADD) || (fn == FN_SUB)));
  endfunction

endpackage

// File: rtl/mc_control_fsm_md.sv
// MULT/DIV watchdog: counts cycles spent waiting for a multiply/divide result and
// flags the last permitted cycle.
module md_watchdog #(
  parameter int MD_TIMEOUT = 40,
  parameter int EN_MDTO    = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CNT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MD_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Saturates at LIMIT so a disabled watchdog never wraps into a false match.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign timeout = (EN_MDTO != 0) && enable && (cnt == LIMIT);

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute with memory wait-states,
// MULT/DIV completion wait and precise exceptions vectored through memory.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MD_TIMEOUT = 40,
  parameter int EN_MDTO    = 1,
  parameter int VEC_OPC    = 255,
  parameter int VEC_DZ     = 254,
  parameter int VEC_OVF    = 253,
  parameter int VEC_MDTO   = 252
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic              divisor_zero,
  input  logic              mult_done,
  input  logic              div_done,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic [1:0]        iord,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic              reg_write,
  output logic [1:0]        reg_dst,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [3:0]        alu_op,
  output logic [2:0]        wb_src,
  output logic              mult_start,
  output logic              div_start,
  output logic              hi_write,
  output logic              lo_write,
  output logic              epc_write,
  output logic [2:0]        exc_code,
  output logic [DATA_W-1:0] exc_vector
);

  state_t  state, next_state;
  exc_t    exc_q, exc_d;
  iclass_t iclass;
  logic    ovf_latch;
  logic    md_done, md_timeout, wd_clear, wd_enable;

  assign iclass    = decode_class(opcode, funct);
  assign md_done   = (iclass == IC_MULT) ? mult_done : div_done;
  assign wd_enable = (state == S_MD_WAIT);
  assign wd_clear  = (state != S_MD_WAIT) || (next_state != S_MD_WAIT);

  md_watchdog #(
    .MD_TIMEOUT (MD_TIMEOUT),
    .EN_MDTO    (EN_MDTO)
  ) u_md_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .timeout (md_timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_RESET;
    end else begin
      state <= next_state;
    end
  end

  // exc_code is captured on the transition into EXC_SAVE and held until the next one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exc_q     <= EXC_NONE;
      ovf_latch <= 1'b0;
    end else begin
      if (next_state == S_EXC_SAVE) begin
        exc_q <= exc_d;
      end
      if ((state == S_EXEC) && ((iclass == IC_RALU) || (iclass == IC_ADDI))) begin
        ovf_latch <= alu_overflow && is_arith(opcode, funct);
      end else if (state == S_EXC_JUMP) begin
        ovf_latch <= 1'b0;
      end
    end
  end

  assign exc_code = exc_q;

  always_comb begin
    case (exc_q)
      EXC_OVF:  exc_vector = DATA_W'(VEC_OVF);
      EXC_DZ:   exc_vector = DATA_W'(VEC_DZ);
      EXC_MDTO: exc_vector = DATA_W'(VEC_MDTO);
      EXC_OPC:  exc_vector = DATA_W'(VEC_OPC);
      default:  exc_vector = '0;
    endcase
  end

  always_comb begin
    next_state = state;
    exc_d      = exc_q;
    pc_write   = 1'b0;
    pc_src     = PCSRC_ALU;
    iord       = IORD_PC;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = REGDST_RT;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALU_ADD;
    wb_src     = WB_ALUOUT;
    mult_start = 1'b0;
    div_start  = 1'b0;
    hi_write   = 1'b0;
    lo_write   = 1'b0;
    epc_write  = 1'b0;
    case (state)
      S_RESET: next_state = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_4;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        if (iclass == IC_INVALID) begin
          next_state = S_EXC_SAVE;
          exc_d      = EXC_OPC;
        end else begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        next_state = S_FETCH;
        case (iclass)
          IC_RALU: begin
            alu_src_a  = 1'b1;
            alu_op     = ALU_FUNCT;
            next_state = S_WB;
          end
          IC_ADDI: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            next_state = S_WB;
          end
          IC_LW, IC_SW: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            next_state = S_MEM;
          end
          IC_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = PCSRC_ALUOUT;
            pc_write  = (alu_zero == (opcode == OP_BEQ));
          end
          IC_JUMP: begin
            pc_write = 1'b1;
            pc_src   = PCSRC_JUMP;
          end
          IC_JAL: begin
            pc_write  = 1'b1;
            pc_src    = PCSRC_JUMP;
            reg_write = 1'b1;
            reg_dst   = REGDST_RA;
            wb_src    = WB_PC;
          end
          IC_JR: begin
            pc_write  = 1'b1;
            alu_src_a = 1'b1;
          end
          IC_MULT: begin
            mult_start = 1'b1;
            next_state = S_MD_WAIT;
          end
          IC_DIV: begin
            // A zero divisor is trapped before the divider is ever started.
            if (divisor_zero) begin
              next_state = S_EXC_SAVE;
              exc_d      = EXC_DZ;
            end else begin
              div_start  = 1'b1;
              next_state = S_MD_WAIT;
            end
          end
          IC_MFHI, IC_MFLO: begin
            reg_write = 1'b1;
            reg_dst   = REGDST_RD;
            wb_src    = (iclass == IC_MFHI) ? WB_HI : WB_LO;
          end
          default: next_state = S_FETCH;
        endcase
      end
      S_MD_WAIT: begin
        if (md_done) begin
          hi_write   = 1'b1;
          lo_write   = 1'b1;
          next_state = S_FETCH;
        end else if (md_timeout) begin
          next_state = S_EXC_SAVE;
          exc_d      = EXC_MDTO;
        end
      end
      S_MEM: begin
        iord = IORD_ALUOUT;
        if (iclass == IC_SW) begin
          mem_write = 1'b1;
          if (mem_ready) next_state = S_FETCH;
        end else begin
          mem_read = 1'b1;
          if (mem_ready) next_state = S_WB;
        end
      end
      S_WB: begin
        reg_dst = (iclass == IC_RALU) ? REGDST_RD : REGDST_RT;
        wb_src  = (iclass == IC_LW) ? WB_MDR : WB_ALUOUT;
        if (ovf_latch) begin
          next_state = S_EXC_SAVE;
          exc_d      = EXC_OVF;
        end else begin
          reg_write  = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_EXC_SAVE: begin
        alu_src_b  = SRCB_4;
        alu_op     = ALU_SUB;
        epc_write  = 1'b1;
        next_state = S_EXC_LOAD;
      end
      S_EXC_LOAD: begin
        iord     = IORD_VEC;
        mem_read = 1'b1;
        if (mem_ready) next_state = S_EXC_JUMP;
      end
      S_EXC_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PCSRC_MDR;
        next_state = S_FETCH;
      end
      default: next_state = S_RESET;
    endcase
  end

endmodule
